// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop rx synchroniser, mid-bit sampling, start-glitch rejection,
// framing check. Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    localparam logic [PW-1:0] PS_END = PW'(DIV - 1);
    localparam logic [TW-1:0] TC_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_END = BW'(DATA_BITS - 1);
    localparam logic          SC_END = 1'(STOP_BITS - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_os: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [PW-1:0]        pcnt;
    logic [TW-1:0]        tc;
    logic [BW-1:0]        bcnt;
    logic                 sc;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
    logic                 done;
`ifdef UART_RX_PARITY_EN
    logic                 perr;
`endif

    logic          tick_c;
    logic          mid_c;
    logic [TW-1:0] tc_nxt_c;

    assign tick_c   = (pcnt == PS_END);
    assign mid_c    = tick_c && (tc == TC_END);
    assign tc_nxt_c = (tc == TC_END) ? '0 : tc + 1'b1;

    // Line synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pcnt       <= '0;
            tc         <= '0;
            bcnt       <= '0;
            sc         <= 1'b0;
            shreg      <= '0;
            ferr       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr       <= 1'b0;
`endif
        end else begin
            // Frame result is published one clk after the final stop sample.
            rx_valid   <= done;
            frame_err  <= done & ferr;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= done & perr;
`endif
            if (done) begin
                rx_data <= shreg;
            end
            done <= 1'b0;

            if (state == IDLE) begin
                pcnt <= '0;
                tc   <= '0;
            end else begin
                pcnt <= tick_c ? '0 : pcnt + 1'b1;
                if (tick_c) begin
                    tc <= tc_nxt_c;
                end
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick_c && tc == TC_MID) begin
                        tc <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            bcnt  <= '0;
                            ferr  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (mid_c) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bcnt == BC_END) begin
                            sc    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_c) begin
                        perr  <= ((^shreg) ^ rxs) != 1'(PARITY_ODD);
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (mid_c) begin
                        ferr <= ferr | ~rxs;
                        if (sc == SC_END) begin
                            done  <= 1'b1;
                            state <= rxs ? IDLE : BREAK;
                            busy  <= ~rxs;
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // A line held low must go high before another start is accepted.
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 1.6 MHz / 10 kbaud / x16 (160 clk per bit).
module tb_uart_rx_os;

    localparam int BIT = 160;
    localparam int CLK_PERIOD = 10;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         n_vec;
    int         n_err;
    int         vcnt;
    int         vbase;
    logic [7:0] log_data [0:31];
    logic       cap_ferr;
    logic       cap_perr;
    logic [7:0] cap_data;
    longint     t_valid;
    longint     t_fall;
    logic       prev_valid;
    logic       stray;
    longint     lat;

    uart_rx_os #(
        .CLK_FREQ  (1600000),
        .BAUD_RATE (10000),
        .OVERSAMPLE(16),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every rx_valid pulse; flags outside a pulse or multi-cycle pulses are sticky errors.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (vcnt < 32) log_data[vcnt] = rx_data;
            cap_data = rx_data;
            cap_ferr = frame_err;
            cap_perr = parity_err;
            t_valid  = $time;
            vcnt     = vcnt + 1;
            if (prev_valid) stray = 1'b1;
        end else if (frame_err || parity_err) begin
            stray = 1'b1;
        end
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge; leaves the line at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_v,
                              input logic stop_v);
        t_fall = $time;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        if (par_en) hold(par_v, BIT);
        hold(stop_v, BIT);
    endtask

    initial begin
        n_vec = 0; n_err = 0; vcnt = 0; stray = 1'b0; prev_valid = 1'b0;
        cap_ferr = 1'b0; cap_perr = 1'b0; cap_data = '0; t_valid = 0; t_fall = 0;
        rx = 1'b1;
        rst_n = 1'b0;

        // 1: reset with a toggling line
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx = (i % 3) == 0;
        end
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_no_valid", vcnt, 0);

        // 2: frame 0xA5, good stop, latency and busy window
        vbase = vcnt;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                repeat (800) @(negedge clk);
                check("a5_busy_mid", {31'd0, busy}, 32'd1);
            end
        join
        lat = (t_valid - t_fall) / CLK_PERIOD;
        check("a5_count", vcnt - vbase, 1);
        check("a5_data", {24'd0, cap_data}, 32'hA5);
        check("a5_ferr", {31'd0, cap_ferr}, 32'd0);
        check("a5_perr", {31'd0, cap_perr}, 32'd0);
        check("a5_latency_1523_1524", (lat >= 1523 && lat <= 1524) ? lat : 0, lat);
        check("a5_latency_value", lat, 1524);
        repeat (20) @(negedge clk);
        check("a5_busy_end", {31'd0, busy}, 32'd0);

        // 3: 40-clk low glitch is rejected
        vbase = vcnt;
        hold(1'b0, 20);
        check("glitch_busy_seen", {31'd0, busy}, 32'd1);
        hold(1'b0, 20);
        hold(1'b1, 45);
        check("glitch_busy_85", {31'd0, busy}, 32'd0);
        hold(1'b1, 300);
        check("glitch_no_valid", vcnt - vbase, 0);

        // 4: framing error followed by a held-low line
        vbase = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("brk_count", vcnt - vbase, 1);
        check("brk_data", {24'd0, cap_data}, 32'h3C);
        check("brk_ferr", {31'd0, cap_ferr}, 32'd1);
        hold(1'b0, 2000);
        check("brk_busy_held", {31'd0, busy}, 32'd1);
        check("brk_no_second", vcnt - vbase, 1);
        hold(1'b1, 10);
        check("brk_busy_release", {31'd0, busy}, 32'd0);
        hold(1'b1, 200);
        check("brk_no_late", vcnt - vbase, 1);

`ifdef UART_RX_PARITY_EN
        // 5: even parity, correct then wrong parity bit
        vbase = vcnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        check("par_ok_data", {24'd0, cap_data}, 32'h07);
        check("par_ok_perr", {31'd0, cap_perr}, 32'd0);
        hold(1'b1, 50);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("par_bad_data", {24'd0, cap_data}, 32'h07);
        check("par_bad_perr", {31'd0, cap_perr}, 32'd1);
        check("par_count", vcnt - vbase, 2);
        hold(1'b1, 50);
`endif

        // 6: back-to-back frames, then reset in the middle of a third
        vbase = vcnt;
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        check("b2b_count", vcnt - vbase, 2);
        check("b2b_first", {24'd0, log_data[vbase]}, 32'h00);
        check("b2b_second", {24'd0, log_data[vbase + 1]}, 32'hFF);
        vbase = vcnt;
        hold(1'b0, BIT);
        hold(1'b1, 640);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_data_rst", {24'd0, rx_data}, 32'd0);
        check("abort_busy_rst", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 2000);
        check("abort_no_valid", vcnt - vbase, 0);
        check("abort_data_after", {24'd0, rx_data}, 32'd0);

        check("flags_only_with_valid", {31'd0, stray}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
